// File: rtl/mac_stream_accum.sv
`timescale 1ns/1ps
// Streaming multiply-accumulate: sums LEN products of unsigned a_in and signed b_in per run.
// Define MAC_ACC_SAT_EN to clamp the accumulator and raise a sticky sat flag instead of wrapping.
module mac_stream_accum #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned LEN     = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      a_in,
  input  logic [bw-1:0]      b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] psum_out,
  output logic               busy,
  output logic               sat
);

  localparam int unsigned CNT_W  = $clog2(LEN + 1);
  localparam int unsigned PROD_W = 2 * bw + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [psum_bw-1:0] acc_q, acc_d;
  logic                      sat_q, sat_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;

  logic signed [bw:0]        a_ext_c;
  logic signed [bw-1:0]      b_sgn_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [psum_bw-1:0] prod_ext_c;
  logic signed [psum_bw-1:0] acc_upd_c;
  logic                      clip_c;

  // Activation is zero-extended so it multiplies as a non-negative signed value.
  assign a_ext_c    = {1'b0, a_in};
  assign b_sgn_c    = b_in;
  assign prod_c     = PROD_W'(a_ext_c) * PROD_W'(b_sgn_c);
  assign prod_ext_c = psum_bw'(prod_c);

`ifdef MAC_ACC_SAT_EN
  localparam int unsigned SUM_W = psum_bw + 1;
  localparam logic signed [psum_bw-1:0] ACC_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] ACC_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  logic signed [SUM_W-1:0] sum_c;

  assign sum_c = SUM_W'(acc_q) + SUM_W'(prod_ext_c);

  // Overflow shows as a guard bit disagreeing with the result sign bit.
  always_comb begin
    clip_c    = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
    acc_upd_c = sum_c[psum_bw-1:0];
    if (clip_c) begin
      acc_upd_c = sum_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign acc_upd_c = acc_q + prod_ext_c;
  assign clip_c    = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          count_d = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (in_valid && in_ready_q) begin
          acc_d   = acc_upd_c;
          count_d = count_q + CNT_W'(1);
          sat_d   = sat_q | clip_c;
          if (count_q == CNT_W'(LEN - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign psum_out  = acc_q;
  assign busy      = busy_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mac_stream_accum.sv
`timescale 1ns/1ps
// Randomized self-checking bench for mac_stream_accum: three instances (default, LEN=3, psum_bw=8)
// checked against a plain-arithmetic model of the sum of products with wrap or clamp.
module tb_mac_stream_accum;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_s     [3];
  logic       in_valid_s  [3];
  logic       out_ready_s [3];
  logic [3:0] a_s         [3];
  logic [3:0] b_s         [3];
  logic       in_ready_s  [3];
  logic       out_valid_s [3];
  logic       busy_s      [3];
  logic       sat_s       [3];
  logic [15:0] psum0, psum1;
  logic [7:0]  psum2;

  int n_checks = 0;
  int n_errors = 0;
  int qa[$];
  int qb[$];
  longint cur_exp;
  bit     cur_sat;

  always #5 clk = ~clk;

  mac_stream_accum #(.bw(4), .psum_bw(16), .LEN(10)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .a_in(a_s[0]), .b_in(b_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .psum_out(psum0), .busy(busy_s[0]), .sat(sat_s[0]));

  mac_stream_accum #(.bw(4), .psum_bw(16), .LEN(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .a_in(a_s[1]), .b_in(b_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .psum_out(psum1), .busy(busy_s[1]), .sat(sat_s[1]));

  mac_stream_accum #(.bw(4), .psum_bw(8), .LEN(10)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .a_in(a_s[2]), .b_in(b_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .psum_out(psum2), .busy(busy_s[2]), .sat(sat_s[2]));

  function automatic int len_of(input int d);
    return (d == 1) ? 3 : 10;
  endfunction

  function automatic int pw_of(input int d);
    return (d == 2) ? 8 : 16;
  endfunction

  function automatic longint psum_of(input int d);
    case (d)
      0:       return longint'($signed(psum0));
      1:       return longint'($signed(psum1));
      default: return longint'($signed(psum2));
    endcase
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: running sum of a*b, clamped or wrapped to a pw-bit signed range after every beat.
  task automatic model(input int pw, output longint acc, output bit s);
    longint m, hi, lo;
    m   = longint'(1) <<< pw;
    hi  = m / 2 - 1;
    lo  = -(m / 2);
    acc = 0;
    s   = 1'b0;
    foreach (qa[i]) begin
      acc = acc + longint'(qa[i]) * longint'(qb[i]);
`ifdef MAC_ACC_SAT_EN
      if (acc > hi) begin acc = hi; s = 1'b1; end
      else if (acc < lo) begin acc = lo; s = 1'b1; end
`else
      if (acc > hi) acc = acc - m;
      else if (acc < lo) acc = acc + m;
`endif
    end
  endtask

  task automatic fill(input int n, input int fa, input int fb, input bit rnd);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(rnd ? int'($urandom_range(15, 0)) : fa);
      qb.push_back(rnd ? int'($urandom_range(15, 0)) - 8 : fb);
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check($sformatf("%s_in_ready_d%0d", tag, d), in_ready_s[d], 0);
    check($sformatf("%s_out_valid_d%0d", tag, d), out_valid_s[d], 0);
    check($sformatf("%s_busy_d%0d", tag, d), busy_s[d], 0);
  endtask

  // Drives one run of the queued pairs, with ignored noise in IDLE and in the gaps of ACCUM.
  task automatic run(input int d, input int gmin, input int gmax);
    longint exp_acc;
    bit     exp_sat;
    model(pw_of(d), exp_acc, exp_sat);
    repeat (2) begin
      in_valid_s[d] = 1'b1;
      a_s[d] = 4'($urandom);
      b_s[d] = 4'($urandom);
      @(negedge clk);
      check($sformatf("idle_in_ready_d%0d", d), in_ready_s[d], 0);
    end
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d]    = 1'b0;
    in_valid_s[d] = 1'b0;
    check($sformatf("run_busy_d%0d", d), busy_s[d], 1);
    for (int i = 0; i < qa.size(); i++) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        in_valid_s[d] = 1'b0;
        start_s[d]    = 1'($urandom_range(1, 0));
        a_s[d]        = 4'($urandom);
        b_s[d]        = 4'($urandom);
        @(negedge clk);
      end
      start_s[d] = 1'b0;
      check($sformatf("beat%0d_in_ready_d%0d", i, d), in_ready_s[d], 1);
      check($sformatf("beat%0d_out_valid_d%0d", i, d), out_valid_s[d], 0);
      in_valid_s[d] = 1'b1;
      a_s[d]        = 4'(qa[i]);
      b_s[d]        = 4'(qb[i]);
      @(negedge clk);
    end
    in_valid_s[d] = 1'b0;
    check($sformatf("done_out_valid_d%0d", d), out_valid_s[d], 1);
    check($sformatf("done_in_ready_d%0d", d), in_ready_s[d], 0);
    check($sformatf("done_busy_d%0d", d), busy_s[d], 1);
    check($sformatf("done_psum_d%0d", d), psum_of(d), exp_acc);
    check($sformatf("done_sat_d%0d", d), sat_s[d], longint'(exp_sat));
    cur_exp = exp_acc;
    cur_sat = exp_sat;
  endtask

  // Holds the result for a while with noise on start/in_valid, then hands it off.
  task automatic drain(input int d, input int hold);
    repeat (hold) begin
      out_ready_s[d] = 1'b0;
      in_valid_s[d]  = 1'($urandom_range(1, 0));
      start_s[d]     = 1'($urandom_range(1, 0));
      a_s[d]         = 4'($urandom);
      b_s[d]         = 4'($urandom);
      @(negedge clk);
      check($sformatf("hold_out_valid_d%0d", d), out_valid_s[d], 1);
      check($sformatf("hold_psum_d%0d", d), psum_of(d), cur_exp);
      check($sformatf("hold_sat_d%0d", d), sat_s[d], longint'(cur_sat));
    end
    in_valid_s[d]  = 1'b0;
    start_s[d]     = 1'b0;
    out_ready_s[d] = 1'b1;
    @(negedge clk);
    out_ready_s[d] = 1'b0;
    check_idle(d, "handoff");
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0; in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0;
      a_s[d] = '0; b_s[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_idle(d, "reset");
      check($sformatf("reset_psum_d%0d", d), psum_of(d), 0);
      check($sformatf("reset_sat_d%0d", d), sat_s[d], 0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Largest negative product every beat, back-to-back, then a long stall on out_ready.
    fill(10, 15, -8, 1'b0);
    run(0, 0, 0);
    check("max_neg_psum", psum_of(0), -1200);
    check("max_neg_sat", sat_s[0], 0);
    drain(0, 5);

    // Short run with two idle cycles between beats.
    qa = '{1, 2, 3};
    qb = '{1, -1, 2};
    run(1, 2, 2);
    check("len3_psum", psum_of(1), 5);
    drain(1, 1);

    // Narrow accumulator overflow.
    fill(10, 15, 7, 1'b0);
    run(2, 0, 1);
`ifdef MAC_ACC_SAT_EN
    check("narrow_psum", psum_of(2), 127);
    check("narrow_sat", sat_s[2], 1);
`else
    check("narrow_psum", psum_of(2), 26);
    check("narrow_sat", sat_s[2], 0);
`endif
    drain(2, 2);

    // Asynchronous reset in the middle of a run.
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) begin
      in_valid_s[0] = 1'b1; a_s[0] = 4'd15; b_s[0] = 4'd7;
      @(negedge clk);
    end
    in_valid_s[0] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_idle(0, "midreset");
    check("midreset_psum", psum_of(0), 0);
    check("midreset_sat", sat_s[0], 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      in_valid_s[0] = 1'b1; a_s[0] = 4'($urandom); b_s[0] = 4'($urandom);
      @(negedge clk);
      check("postreset_in_ready", in_ready_s[0], 0);
      check("postreset_psum", psum_of(0), 0);
    end
    in_valid_s[0] = 1'b0;
    fill(10, 1, 1, 1'b0);
    run(0, 0, 1);
    check("postreset_run_psum", psum_of(0), 10);
    drain(0, 0);

    // Random pairs, random gaps and random consumer stalls on every instance.
    for (int r = 0; r < 12; r++) begin
      int d;
      d = r % 3;
      fill(len_of(d), 0, 0, 1'b1);
      run(d, 0, 3);
      drain(d, int'($urandom_range(3, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
